// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and RV32I load/store funct3 codes for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores and lane select/extension for loads,
// plus misalignment and illegal-funct3 detection.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    logic        w_illegal;
    logic        w_misal;
    logic [31:0] w_sh;

    always_comb begin
        w_illegal = i_we ? !(i_funct3 inside {F3_B, F3_H, F3_W})
                         : !(i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        w_misal   = (i_funct3[1:0] == 2'b01 && i_addr[0]) || (i_funct3[1:0] == 2'b10 && i_addr != 2'b00);
        o_err     = w_illegal || w_misal;
        w_sh      = i_rword >> {i_addr, 3'b000};
        o_rdata   = o_err                ? 32'h0 :
                    i_funct3 == F3_B     ? {{24{w_sh[7]}}, w_sh[7:0]} :
                    i_funct3 == F3_BU    ? {24'h0, w_sh[7:0]} :
                    i_funct3 == F3_H     ? {{16{w_sh[15]}}, w_sh[15:0]} :
                    i_funct3 == F3_HU    ? {16'h0, w_sh[15:0]} : w_sh;
        o_be      = o_err                    ? 4'b0000 :
                    i_funct3[1:0] == 2'b00   ? 4'b0001 << i_addr :
                    i_funct3[1:0] == 2'b01   ? 4'b0011 << i_addr : 4'b1111;
        o_wdata   = i_wdata << {i_addr, 3'b000};
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with WAIT_STATES access latency,
// byte-addressed little-endian RAM and RV32I load extension.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 17,
    parameter int WAIT_STATES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err
);

    localparam int WORDS = 2 ** (MEM_ADDR_BITS - 2);
    localparam int CW    = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;

    dmem_state_t              r_state, w_next;
    logic [CW-1:0]            r_cnt, w_cnt_next;
    logic                     r_we, r_err;
    logic [2:0]               r_f3;
    logic [MEM_ADDR_BITS-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata, r_rdata;
    logic [31:0]              r_mem [WORDS];

    logic                     w_accept, w_enter_resp, w_live, w_we, w_err;
    logic [2:0]               w_f3;
    logic [MEM_ADDR_BITS-1:0] w_addr;
    logic [DATA_WIDTH-1:0]    w_wdata, w_wsh, w_rext, w_word;
    logic [3:0]               w_be;
    logic                     w_unused;

    assign req_ready    = rst && r_state == IDLE;
    assign resp_valid   = r_state == RESP;
    assign resp_rdata   = r_rdata;
    assign resp_err     = r_err;
    assign w_accept     = req_valid && req_ready;
    assign w_enter_resp = w_next == RESP && r_state != RESP;
    assign w_unused     = ^req_addr[ADDRESS_WIDTH-1:MEM_ADDR_BITS];

    // With zero wait states the access happens on the accept edge, so use the live request.
    assign w_live  = r_state == IDLE;
    assign w_we    = w_live ? req_we : r_we;
    assign w_f3    = w_live ? req_funct3 : r_f3;
    assign w_addr  = w_live ? req_addr[MEM_ADDR_BITS-1:0] : r_addr;
    assign w_wdata = w_live ? req_wdata : r_wdata;
    assign w_word  = r_mem[w_addr[MEM_ADDR_BITS-1:2]];

    dmem_lane_align u_align (
        .i_we     (w_we),
        .i_funct3 (w_f3),
        .i_addr   (w_addr[1:0]),
        .i_wdata  (w_wdata),
        .i_rword  (w_word),
        .o_be     (w_be),
        .o_wdata  (w_wsh),
        .o_rdata  (w_rext),
        .o_err    (w_err)
    );

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: if (w_accept) begin
                w_next     = WAIT_STATES == 0 ? RESP : WAIT;
                w_cnt_next = CW'(WAIT_STATES - 1);
            end
            WAIT: if (r_cnt == '0) w_next = RESP; else w_cnt_next = r_cnt - 1'b1;
            RESP: if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr[MEM_ADDR_BITS-1:0];
                r_wdata <= req_wdata;
            end
            if (w_enter_resp) begin
                r_rdata <= w_we ? '0 : w_rext;
                r_err   <= w_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enter_resp && w_we && !w_err)
            for (int i = 0; i < 4; i++)
                if (w_be[i]) r_mem[w_addr[MEM_ADDR_BITS-1:2]][8*i +: 8] <= w_wsh[8*i +: 8];
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench; instance 1 (2 wait states) carries the functional
// traffic, instances 0 and 2 (0 and 3 wait states) cover response latency.
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld [3];
    logic        we, rr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        rdy [3];
    logic        rv  [3];
    logic        er  [3];
    logic [31:0] rd  [3];
    exp_t        sb  [$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gd
        dmem_responder #(.WAIT_STATES(g == 0 ? 0 : g == 1 ? 2 : 3)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (vld[g]),
            .req_ready  (rdy[g]),
            .req_we     (we),
            .req_funct3 (f3),
            .req_addr   (addr),
            .req_wdata  (wdata),
            .resp_valid (rv[g]),
            .resp_ready (rr),
            .resp_rdata (rd[g]),
            .resp_err   (er[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input string tag, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_er, input int hold);
        exp_t e;
        int   n;
        sb.push_back('{exp_rd, exp_er});
        @(negedge clk);
        we = w; f3 = f; addr = a; wdata = d; vld[1] = 1'b1; rr = (hold == 0);
        n = 0;
        while (!rdy[1] && n < 20) begin @(negedge clk); n++; end
        chk({tag, ".req_ready"}, rdy[1], 1);
        @(posedge clk);
        #1 vld[1] = 1'b0;
        n = 0;
        while (!rv[1] && n < 20) begin @(negedge clk); n++; end
        chk({tag, ".resp_valid"}, rv[1], 1);
        e = sb.pop_front();
        chk({tag, ".rdata"}, rd[1], e.rdata);
        chk({tag, ".err"}, er[1], e.err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, rv[1], 1);
            chk({tag, ".hold_rdata"}, rd[1], e.rdata);
            chk({tag, ".hold_err"}, er[1], e.err);
            chk({tag, ".hold_ready"}, rdy[1], 0);
        end
        if (hold > 0) begin
            rr = 1'b1;
            @(posedge clk);
            #1;
            chk({tag, ".released_valid"}, rv[1], 0);
            chk({tag, ".released_ready"}, rdy[1], 1);
        end
    endtask

    task automatic lat(input int i, input int w);
        int n;
        @(negedge clk);
        we = 1'b0; f3 = F3_W; addr = 32'h0; rr = 1'b1; vld[i] = 1'b1;
        chk($sformatf("lat%0d.ready", w), rdy[i], 1);
        @(posedge clk);
        #1 vld[i] = 1'b0;
        n = 0;
        while (!rv[i] && n < 20) begin @(posedge clk); #1 n++; end
        chk($sformatf("lat%0d.edges", w), n, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vld = '{1'b0, 1'b0, 1'b0};
        we = 1'b0; f3 = F3_W; addr = 32'h0; wdata = 32'h0; rr = 1'b1;
        #1 rst = 1'b0;
        #10;
        chk("rst.req_ready", rdy[1], 0);
        chk("rst.resp_valid", rv[1], 0);
        chk("rst.rdata", rd[1], 0);
        chk("rst.err", er[1], 0);
        @(negedge clk) rst = 1'b1;
        #1 chk("rst.ready_after", rdy[1], 1);

        xact("sw100", 1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
        xact("lw100", 0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        xact("sw104", 1, F3_W, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0);
        xact("sb105", 1, F3_B, 32'h105, 32'hFFFFFF80, 32'h0, 0, 0);
        xact("lb105", 0, F3_B, 32'h105, 32'h0, 32'hFFFFFF80, 0, 0);
        xact("lbu105", 0, F3_BU, 32'h105, 32'h0, 32'h00000080, 0, 0);
        xact("lw104", 0, F3_W, 32'h104, 32'h0, 32'hDEAD80EF, 0, 0);
        xact("sh106", 1, F3_H, 32'h106, 32'h1234A5C3, 32'h0, 0, 0);
        xact("lh106", 0, F3_H, 32'h106, 32'h0, 32'hFFFFA5C3, 0, 0);
        xact("lhu106", 0, F3_HU, 32'h106, 32'h0, 32'h0000A5C3, 0, 0);
        xact("lw104b", 0, F3_W, 32'h104, 32'h0, 32'hA5C380EF, 0, 0);
        xact("lw102", 0, F3_W, 32'h102, 32'h0, 32'h0, 1, 0);
        xact("sh101", 1, F3_H, 32'h101, 32'h0000FFFF, 32'h0, 1, 0);
        xact("lh103", 0, F3_H, 32'h103, 32'h0, 32'h0, 1, 0);
        xact("ld_f3_011", 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 0);
        xact("st_f3_100", 1, F3_BU, 32'h100, 32'h0, 32'h0, 1, 0);
        xact("lw100_kept", 0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        xact("sw_wrap", 1, F3_W, 32'h00020300, 32'h11223344, 32'h0, 0, 0);
        xact("lw_wrap", 0, F3_W, 32'h300, 32'h0, 32'h11223344, 0, 0);
        xact("lw_stall", 0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 5);

        lat(0, 0);
        lat(1, 2);
        lat(2, 3);

        // Reset while a load response is waiting to be consumed.
        @(negedge clk);
        we = 1'b0; f3 = F3_W; addr = 32'h100; vld[1] = 1'b1; rr = 1'b0;
        chk("rstresp.ready", rdy[1], 1);
        @(posedge clk);
        #1 vld[1] = 1'b0;
        n = 0;
        while (!rv[1] && n < 20) begin @(negedge clk); n++; end
        chk("rstresp.valid_before", rv[1], 1);
        #2 rst = 1'b0;
        #1;
        chk("rstresp.valid_drop", rv[1], 0);
        chk("rstresp.rdata", rd[1], 0);
        chk("rstresp.req_ready", rdy[1], 0);
        @(negedge clk) rst = 1'b1;
        rr = 1'b1;

        xact("sw200", 1, F3_W, 32'h200, 32'hCAFEF00D, 32'h0, 0, 0);
        @(negedge clk);
        we = 1'b1; f3 = F3_W; addr = 32'h200; wdata = 32'h12345678; vld[1] = 1'b1;
        chk("rstwait.ready", rdy[1], 1);
        @(posedge clk);
        #1 vld[1] = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rstwait.valid", rv[1], 0);
        chk("rstwait.req_ready", rdy[1], 0);
        @(negedge clk) rst = 1'b1;
        xact("lw200_old", 0, F3_W, 32'h200, 32'h0, 32'hCAFEF00D, 0, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
